pipe_stage_skid: RTL and testbench

//  Parametrised pipeline-stage register for the CPU generator. Replaces fixed
//  en/clear stage latches with a valid/ready elastic stage. A 2-entry skid

---
 rtl/pipe_stage_skid.sv | 137 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_skid : valid/ready elastic pipeline stage with a 2-entry skid    |
// |                   buffer and a RAW hazard query over both held beats.      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int CTRL_W   = 7,
  parameter int WEN_BIT  = 0,
  parameter int ADDR_LSB = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  input  logic [ADDR_W-1:0] hz_addr_i,
  output logic              hz_hit_o
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;

  logic w_acc;
  logic w_pop;

  assign w_acc = in_valid_i & in_ready_q;
  assign w_pop = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (clear_i) begin
      // Flush wins over any same-cycle accept or pop.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      skid_data_d  = '0;
    end else if (!main_valid_q) begin
      if (w_acc) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl_i;
        main_data_d  = in_data_i;
      end
    end else if (w_pop) begin
      if (skid_valid_q) begin
        // in_ready is low whenever the skid is full, so no accept here.
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
        skid_data_d  = '0;
      end else if (w_acc) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl_i;
        main_data_d  = in_data_i;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
        main_data_d  = '0;
      end
    end else if (w_acc) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl_i;
      skid_data_d  = in_data_i;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_valid_q;
  assign out_ctrl_o  = main_valid_q ? main_ctrl_q : '0;
  assign out_data_o  = main_valid_q ? main_data_q : '0;
  assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  logic [1:0]        w_ent_valid;
  logic [CTRL_W-1:0] w_ent_ctrl [2];
  logic [1:0]        w_ent_hit;

  assign w_ent_valid   = {skid_valid_q, main_valid_q};
  assign w_ent_ctrl[0] = main_ctrl_q;
  assign w_ent_ctrl[1] = skid_ctrl_q;

  for (genvar e = 0; e < 2; e++) begin : g_hz
    assign w_ent_hit[e] = w_ent_valid[e]
                        & w_ent_ctrl[e][WEN_BIT]
                        & (w_ent_ctrl[e][ADDR_LSB +: ADDR_W] == hz_addr_i)
                        & (hz_addr_i != '0);
  end

  assign hz_hit_o = |w_ent_hit;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_stage_skid : directed and randomized bench against a queue model.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_skid;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [AW-1:0] hz_addr;
  logic          hz_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .WEN_BIT(0), .ADDR_LSB(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl), .out_data_o(out_data),
    .occupancy_o(occupancy), .hz_addr_i(hz_addr), .hz_hit_o(hz_hit)
  );

  // Reference: an ordered FIFO of at most two beats.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;
  beat_t mq[$];
  bit    accepted;

  function automatic bit model_hit(input logic [AW-1:0] a);
    bit h = 1'b0;
    foreach (mq[i]) if (mq[i].c[0] && mq[i].c[AW:1] == a && a != '0) h = 1'b1;
    return h;
  endfunction

  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic r, input logic clr);
    bit    acc, pop;
    beat_t b;
    in_valid = v; in_ctrl = c; in_data = d; out_ready = r; clear = clr;
    acc = v && (mq.size() < 2);
    pop = (mq.size() > 0) && r;
    @(posedge clk);
    accepted = 1'b0;
    if (clr) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin b.c = c; b.d = d; mq.push_back(b); accepted = 1'b1; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 0; in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0; hz_addr = '0;
    #12;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL reset_init rdy=%b vld=%b occ=%0d need 1 0 0", in_ready, out_valid, occupancy); end
    @(negedge clk) rst_n = 1'b1;
    step(1, 7'h13, 32'h11, 0, 0);
    step(1, 7'h15, 32'h22, 0, 0);
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_fill occ=%0d rdy=%b need 2 0", occupancy, in_ready); end
    #3 rst_n = 1'b0;
    #1;
    mq.delete();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_async occ=%0d vld=%b data=%h ctrl=%h rdy=%b need 0 0 0 0 1",
                         occupancy, out_valid, out_data, out_ctrl, in_ready); end
    @(negedge clk) rst_n = 1'b1;
    step(1, 7'h02, 32'hA5, 1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5 || occupancy !== 2'd1) begin
      errors++; $display("FAIL reset_resume vld=%b data=%h occ=%0d need 1 a5 1", out_valid, out_data, occupancy); end
    step(0, '0, '0, 1, 0);
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 8; k++) begin
      step(1, CW'($urandom), DW'(k), 1, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(k) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL stream k=%0d vld=%b data=%0d occ=%0d rdy=%b need 1 %0d 1 1",
                           k, out_valid, out_data, occupancy, in_ready, k); end
    end
    step(0, '0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL stream_drain vld=%b occ=%0d need 0 0", out_valid, occupancy); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] seen[$];
    bit            csent = 1'b0;
    step(1, 7'h21, 32'hA, 0, 0);
    step(1, 7'h22, 32'hB, 0, 0);
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
      errors++; $display("FAIL bp_fill occ=%0d rdy=%b data=%h need 2 0 a", occupancy, in_ready, out_data); end
    step(1, 7'h23, 32'hC, 0, 0);
    checks++; if (occupancy !== 2'd2 || out_data !== 32'hA || out_ctrl !== 7'h21) begin
      errors++; $display("FAIL bp_hold occ=%0d data=%h ctrl=%h need 2 a 21", occupancy, out_data, out_ctrl); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen.push_back(out_data);
      step(!csent, 7'h23, 32'hC, 1, 0);
      if (accepted) csent = 1'b1;
      if (csent && !out_valid) break;
    end
    checks++; if (seen.size() != 3 || seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC) begin
      errors++; $display("FAIL bp_order n=%0d seq=%p need A B C", seen.size(), seen); end
  endtask

  task automatic test_flush();
    step(1, 7'h31, 32'h1, 0, 0);
    step(1, 7'h33, 32'h2, 0, 0);
    step(1, 7'h35, 32'hDD, 1, 1);
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush occ=%0d vld=%b ctrl=%h data=%h rdy=%b need 0 0 0 0 1",
                         occupancy, out_valid, out_ctrl, out_data, in_ready); end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, '0, 1, 0);
      checks++; if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_absent cyc=%0d vld=%b data=%h need 0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_hazard();
    step(1, {1'b1, 5'd5, 1'b1}, 32'h55, 0, 0);
    step(1, {1'b0, 5'd7, 1'b0}, 32'h77, 0, 0);
    hz_addr = 5'd5; #1;
    checks++; if (hz_hit !== 1'b1) begin errors++; $display("FAIL hz_main5 got=%b need 1", hz_hit); end
    hz_addr = 5'd7; #1;
    checks++; if (hz_hit !== 1'b0) begin errors++; $display("FAIL hz_skid7_noen got=%b need 0", hz_hit); end
    step(0, '0, '0, 0, 1);
    step(1, {1'b0, 5'd0, 1'b1}, 32'h0, 0, 0);
    step(1, {1'b1, 5'd9, 1'b1}, 32'h99, 0, 0);
    hz_addr = 5'd0; #1;
    checks++; if (hz_hit !== 1'b0) begin errors++; $display("FAIL hz_reg0 got=%b need 0", hz_hit); end
    hz_addr = 5'd9; #1;
    checks++; if (hz_hit !== 1'b1) begin errors++; $display("FAIL hz_skid9 got=%b need 1", hz_hit); end
    hz_addr = 5'd5; #1;
    checks++; if (hz_hit !== 1'b0) begin errors++; $display("FAIL hz_stale5 got=%b need 0", hz_hit); end
    step(0, '0, '0, 0, 1);
    hz_addr = 5'd9; #1;
    checks++; if (hz_hit !== 1'b0) begin errors++; $display("FAIL hz_empty got=%b need 0", hz_hit); end
    hz_addr = '0;
  endtask

  task automatic test_simultaneous();
    step(1, 7'h41, 32'h51, 0, 0);
    step(1, 7'h43, 32'h52, 0, 0);
    in_valid = 1'b1; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sim_rdy_low got=%b need 0", in_ready); end
    step(1, 7'h45, 32'hE0, 1, 0);
    checks++; if (out_data !== 32'h52 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL sim_skid_move data=%h occ=%0d rdy=%b need 52 1 1", out_data, occupancy, in_ready); end
    step(1, 7'h45, 32'hE0, 1, 0);
    checks++; if (out_data !== 32'hE0 || occupancy !== 2'd1) begin
      errors++; $display("FAIL sim_take_next data=%h occ=%0d need e0 1", out_data, occupancy); end
    step(0, '0, '0, 1, 0);
  endtask

  task automatic test_random();
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, CW'($urandom), DW'($urandom), ($urandom % 3) != 0, ($urandom % 20) == 0);
      if (mq.size() > 0 && ($urandom % 2) == 1) hz_addr = mq[$urandom % mq.size()].c[AW:1];
      else hz_addr = AW'($urandom);
      #1;
      ed = (mq.size() > 0) ? mq[0].d : '0;
      ec = (mq.size() > 0) ? mq[0].c : '0;
      checks++; if (out_valid !== (mq.size() > 0) || out_data !== ed || out_ctrl !== ec) begin
        errors++; $display("FAIL rnd_head cyc=%0d vld=%b data=%h ctrl=%h need %b %h %h",
                           i, out_valid, out_data, out_ctrl, mq.size() > 0, ed, ec); end
      checks++; if (occupancy !== 2'(mq.size()) || in_ready !== (mq.size() < 2)) begin
        errors++; $display("FAIL rnd_occ cyc=%0d occ=%0d rdy=%b need %0d %b",
                           i, occupancy, in_ready, mq.size(), mq.size() < 2); end
      checks++; if (hz_hit !== model_hit(hz_addr)) begin
        errors++; $display("FAIL rnd_hz cyc=%0d addr=%0d got=%b need %b", i, hz_addr, hz_hit, model_hit(hz_addr)); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_hazard();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
